seq_divider: RTL and testbench

Multi-cycle restoring divider for the ALU datapath. It computes quotient and remainder with one shift-subtract step per clock, which keeps division off the single-cycle carry-lookahead adder path. The block sits beside the ALU: the controller issues operands with a start pulse and collects results on a one-cycle done pulse.

---
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one shift-subtract step per clock, results on a one-cycle done pulse.
// Define SEQ_DIVIDER_SIGNED_EN to add the div_signed port and two's-complement sign handling.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             div_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg_q;
  logic r_neg_q;
  logic a_neg;
  logic b_neg;

  assign a_neg = div_signed & dividend[WIDTH-1];
  assign b_neg = div_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  // Truncation toward zero: quotient sign is the XOR, remainder follows the dividend.
  assign q_fin = q_neg_q ? -q_d : q_d;
  assign r_fin = r_neg_q ? -rem_d : rem_d;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fin = q_d;
  assign r_fin = rem_d;
`endif

  // One restoring step. The partial remainder is always below the divisor, so bit WIDTH
  // of the (WIDTH+1)-bit difference is exactly the borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    shifted_d = {rem_q, q_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, div_q};
    no_borrow = ~trial_d[WIDTH];
    rem_d     = no_borrow ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    q_d       = {q_q[WIDTH-2:0], no_borrow};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              state_q     <= ST_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q     <= ST_RUN;
              busy        <= 1'b1;
              rem_q       <= '0;
              q_q         <= a_mag;
              div_q       <= b_mag;
              cnt_q       <= CW'(WIDTH - 1);
              div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
              q_neg_q     <= a_neg ^ b_neg;
              r_neg_q     <= a_neg;
`endif
            end
          end
        end

        ST_RUN: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q   <= ST_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes model results, a negedge monitor pops them on done.
// Compile with SEQ_DIVIDER_SIGNED_EN defined to also exercise signed mode.
module tb_seq_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           busy_n;
    int           edge_n;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic         div_signed;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = -1;
  int   busy_cnt = 0;
  logic rst_at_edge = 1'b1;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .div_signed (div_signed),
`endif
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference: plain integer division with the documented zero-divisor and overflow cases.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    e.dbz    = 1'b0;
    e.lat    = W + 1;
    e.busy_n = W;
    e.edge_n = 0;
    if (b == '0) begin
      e.q      = '1;
      e.r      = a;
      e.dbz    = 1'b1;
      e.lat    = 1;
      e.busy_n = 0;
    end else if (s) begin
      if (a == MIN_NEG && b == '1) begin
        e.q = MIN_NEG;
        e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    exp_t e;
    bit   sg;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sg = s;
    div_signed = s;
`else
    sg = 1'b0;
    if (s) sg = 1'b0;
`endif
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (cyc > busy_until) begin
      e = model(a, b, sg);
      e.edge_n   = cyc + e.lat;
      busy_until = cyc + e.lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
`ifdef SEQ_DIVIDER_SIGNED_EN
    div_signed = 1'($urandom);
`endif
  endtask

  task automatic wait_idle();
    int n = 0;
    while (cyc + 1 <= busy_until && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got timeout want idle within 200 cycles");
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), '0);
    sb.delete();
    busy_until = -1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare on every done pulse, and hold-value checks on every other cycle.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      busy_cnt = 0;
      last_q   = '0;
      last_r   = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("busy_with_done", W'(busy), '0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 want no pending operation (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quotient", quotient, e.q);
          check("remainder", remainder, e.r);
          check("div_by_zero", W'(div_by_zero), W'(e.dbz));
          check("done_edge", W'(cyc + 1), W'(e.edge_n));
          check("busy_cycles", W'(busy_cnt), W'(e.busy_n));
          last_q   = e.q;
          last_r   = e.r;
          busy_cnt = 0;
        end
      end else begin
        check("hold_quotient", quotient, last_q);
        check("hold_remainder", remainder, last_r);
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    div_signed = 1'b0;
`endif
    apply_reset(3);

    issue(32'd100, 32'd7, 1'b0);
    wait_idle();
    issue(32'h0000_0005, 32'd0, 1'b0);
    wait_idle();

    // Second start mid-RUN must be dropped; the retry after done is accepted.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (5) @(negedge clk);
    issue(32'd9, 32'd3, 1'b0);
    wait_idle();
    issue(32'd9, 32'd3, 1'b0);
    wait_idle();

    // Abort in RUN, confirm no done pulse, then a clean retry.
    issue(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    apply_reset(1);
    repeat (4) @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    wait_idle();

    issue(32'd3, 32'd10, 1'b0);
    wait_idle();
    repeat (6) @(negedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
    issue(-32'sd7, 32'd2, 1'b1);
    wait_idle();
    issue(MIN_NEG, 32'hFFFF_FFFF, 1'b1);
    wait_idle();
    issue(-32'sd7, 32'd2, 1'b0);
    wait_idle();
    issue(-32'sd5, 32'd0, 1'b1);
    wait_idle();
    issue(32'd7, -32'sd2, 1'b1);
    wait_idle();
`endif

    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 9));
      if (n == 0)      b = '0;
      else if (n <= 3) b = W'($urandom_range(1, 15));
      else if (n == 4) b = '1;
      else             b = $urandom;
      n = int'($urandom_range(0, 5));
      if (n == 0)      a = MIN_NEG;
      else if (n == 1) a = W'($urandom_range(0, 50));
      else             a = $urandom;
      issue(a, b, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat (3) @(negedge clk);
        issue($urandom, $urandom, 1'($urandom));
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", W'(sb.size()), '0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
